// File: rtl/range_sensor_scheduler.sv
// Time-shares one ranging engine across three ultrasonic sensors (front, side-front, side-back).
// Optional build macro FRONT_PRIORITY_EN selects the 4-slot order front, side-front, front, side-back.
module range_sensor_scheduler #(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYCLES_PER_CM = 2900,
  parameter int ECHO_TIMEOUT  = 1500000,
  parameter int GUARD_CYCLES  = 500000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       ENABLE,
  input  logic [2:0] ECHO,
  output logic [2:0] TRIG,
  output logic [7:0] DISTANCE_FRONT,
  output logic [7:0] DISTANCE_SIDE_FRONT,
  output logic [7:0] DISTANCE_SIDE_BACK,
  output logic       DIST_VALID,
  output logic [1:0] DIST_ID,
  output logic       NO_ECHO,
  output logic       BUSY
);

  localparam int PHASE_MAX = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(ECHO_TIMEOUT + 1);
  localparam int SW = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

  localparam logic [PW-1:0] TRIG_LAST  = PW'(TRIG_CYCLES - 1);
  localparam logic [PW-1:0] GUARD_LAST = PW'(GUARD_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(ECHO_TIMEOUT - 1);
  localparam logic [SW-1:0] PRESC_LAST = SW'(CYCLES_PER_CM - 1);

`ifdef FRONT_PRIORITY_EN
  localparam logic [1:0] LAST_SLOT = 2'd3;
`else
  localparam logic [1:0] LAST_SLOT = 2'd2;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GUARD
  } state_e;

  // Maps a slot index onto the sensor fired in that slot.
  function automatic logic [1:0] slot_sensor(input logic [1:0] slot);
`ifdef FRONT_PRIORITY_EN
    case (slot)
      2'd1:    return 2'd1;
      2'd3:    return 2'd2;
      default: return 2'd0;
    endcase
`else
    return slot;
`endif
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      trig_q, trig_d;
  logic [1:0]      slot_q, slot_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   presc_q, presc_d;
  logic [7:0]      cm_q, cm_d;
  logic [7:0]      dist_front_q, dist_front_d;
  logic [7:0]      dist_sf_q, dist_sf_d;
  logic [7:0]      dist_sb_q, dist_sb_d;
  logic            dist_valid_q, dist_valid_d;
  logic            no_echo_q, no_echo_d;
  logic [1:0]      dist_id_q, dist_id_d;
  logic            busy_q, busy_d;
  logic [2:0]      echo_meta_q, echo_meta_d;
  logic [2:0]      echo_sync_q, echo_sync_d;
  logic [2:0]      echo_prev_q, echo_prev_d;

  logic [1:0]      sel;
  logic [1:0]      next_slot;
  logic            echo_now, echo_was, rise, fall, timeout;
  logic [SW-1:0]   presc_n;
  logic [7:0]      cm_n;
  logic            write_en;
  logic [7:0]      write_val;

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    trig_d       = trig_q;
    slot_d       = slot_q;
    phase_d      = phase_q;
    tmo_d        = tmo_q;
    presc_d      = presc_q;
    cm_d         = cm_q;
    dist_front_d = dist_front_q;
    dist_sf_d    = dist_sf_q;
    dist_sb_d    = dist_sb_q;
    dist_valid_d = 1'b0;
    no_echo_d    = 1'b0;
    dist_id_d    = dist_id_q;
    write_en     = 1'b0;
    write_val    = 8'hFF;
    presc_n      = presc_q;
    cm_n         = cm_q;

    echo_meta_d = ECHO;
    echo_sync_d = echo_meta_q;
    echo_prev_d = echo_sync_q;

    sel       = slot_sensor(slot_q);
    next_slot = (slot_q == LAST_SLOT) ? 2'd0 : slot_q + 2'd1;
    echo_now  = echo_sync_q[sel];
    echo_was  = echo_prev_q[sel];
    rise      = echo_now & ~echo_was;
    fall      = ~echo_now & echo_was;
    timeout   = (tmo_q == TMO_LAST);

    // Counting on the delayed sample includes both the rise cycle and the last high cycle.
    if (echo_was) begin
      if (presc_q == PRESC_LAST) begin
        presc_n = '0;
        if (cm_q != 8'hFF) cm_n = cm_q + 8'd1;
      end else begin
        presc_n = presc_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d = S_TRIG;
          trig_d  = 3'b001 << sel;
          phase_d = '0;
        end
      end
      S_TRIG: begin
        if (phase_q == TRIG_LAST) begin
          state_d = S_WAIT_RISE;
          trig_d  = 3'b000;
          tmo_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_WAIT_RISE: begin
        if (timeout) begin
          state_d   = S_GUARD;
          phase_d   = '0;
          no_echo_d = 1'b1;
          dist_id_d = sel;
          write_en  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (rise) begin
            state_d = S_MEASURE;
            presc_d = '0;
            cm_d    = 8'd0;
          end
        end
      end
      S_MEASURE: begin
        presc_d = presc_n;
        cm_d    = cm_n;
        if (fall) begin
          state_d      = S_GUARD;
          phase_d      = '0;
          dist_valid_d = 1'b1;
          dist_id_d    = sel;
          write_en     = 1'b1;
          write_val    = cm_n;
        end else if (timeout) begin
          state_d   = S_GUARD;
          phase_d   = '0;
          no_echo_d = 1'b1;
          dist_id_d = sel;
          write_en  = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (phase_q == GUARD_LAST) begin
          slot_d  = next_slot;
          phase_d = '0;
          if (ENABLE) begin
            state_d = S_TRIG;
            trig_d  = 3'b001 << slot_sensor(next_slot);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        trig_d  = 3'b000;
      end
    endcase

    if (write_en) begin
      case (sel)
        2'd0:    dist_front_d = write_val;
        2'd1:    dist_sf_d    = write_val;
        default: dist_sb_d    = write_val;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      trig_q       <= 3'b000;
      slot_q       <= 2'd0;
      phase_q      <= '0;
      tmo_q        <= '0;
      presc_q      <= '0;
      cm_q         <= 8'd0;
      dist_front_q <= 8'hFF;
      dist_sf_q    <= 8'hFF;
      dist_sb_q    <= 8'hFF;
      dist_valid_q <= 1'b0;
      no_echo_q    <= 1'b0;
      dist_id_q    <= 2'd0;
      busy_q       <= 1'b0;
      echo_meta_q  <= 3'b000;
      echo_sync_q  <= 3'b000;
      echo_prev_q  <= 3'b000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
      state_q      <= state_d;
      trig_q       <= trig_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      tmo_q        <= tmo_d;
      presc_q      <= presc_d;
      cm_q         <= cm_d;
      dist_front_q <= dist_front_d;
      dist_sf_q    <= dist_sf_d;
      dist_sb_q    <= dist_sb_d;
      dist_valid_q <= dist_valid_d;
      no_echo_q    <= no_echo_d;
      dist_id_q    <= dist_id_d;
      busy_q       <= busy_d;
      echo_meta_q  <= echo_meta_d;
      echo_sync_q  <= echo_sync_d;
      echo_prev_q  <= echo_prev_d;
    end
  end

  assign TRIG                = trig_q;
  assign DISTANCE_FRONT      = dist_front_q;
  assign DISTANCE_SIDE_FRONT = dist_sf_q;
  assign DISTANCE_SIDE_BACK  = dist_sb_q;
  assign DIST_VALID          = dist_valid_q;
  assign DIST_ID             = dist_id_q;
  assign NO_ECHO             = no_echo_q;
  assign BUSY                = busy_q;

endmodule

// File: tb/tb_range_sensor_scheduler.sv
// Randomized self-checking bench for range_sensor_scheduler with a slot-level reference model.
// Honours FRONT_PRIORITY_EN for the expected slot order.
module tb_range_sensor_scheduler;

  localparam int TRIG_CYCLES   = 4;
  localparam int CYCLES_PER_CM = 10;
  localparam int ECHO_TIMEOUT  = 4000;
  localparam int GUARD_CYCLES  = 20;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       ENABLE;
  logic [2:0] ECHO;
  logic [2:0] TRIG;
  logic [7:0] DISTANCE_FRONT, DISTANCE_SIDE_FRONT, DISTANCE_SIDE_BACK;
  logic       DIST_VALID, NO_ECHO, BUSY;
  logic [1:0] DIST_ID;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: slot pointer and last written distance per sensor.
  int ptr_m;
  int dist_m[3];

  range_sensor_scheduler #(
    .TRIG_CYCLES  (TRIG_CYCLES),
    .CYCLES_PER_CM(CYCLES_PER_CM),
    .ECHO_TIMEOUT (ECHO_TIMEOUT),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) dut (
    .CLK                (CLK),
    .RESET_N            (RESET_N),
    .ENABLE             (ENABLE),
    .ECHO               (ECHO),
    .TRIG               (TRIG),
    .DISTANCE_FRONT     (DISTANCE_FRONT),
    .DISTANCE_SIDE_FRONT(DISTANCE_SIDE_FRONT),
    .DISTANCE_SIDE_BACK (DISTANCE_SIDE_BACK),
    .DIST_VALID         (DIST_VALID),
    .DIST_ID            (DIST_ID),
    .NO_ECHO            (NO_ECHO),
    .BUSY               (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int slot_count();
`ifdef FRONT_PRIORITY_EN
    return 4;
`else
    return 3;
`endif
  endfunction

  function automatic int order_of(input int p);
`ifdef FRONT_PRIORITY_EN
    int order[4] = '{0, 1, 0, 2};
`else
    int order[4] = '{0, 1, 2, 0};
`endif
    return order[p];
  endfunction

  function automatic int expected_cm(input int n);
    int cm = n / CYCLES_PER_CM;
    return (cm > 255) ? 255 : cm;
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < 3; i++) dist_m[i] = 255;
  endtask

  task automatic check_distances(input string tag);
    check({tag, "_front"}, {24'd0, DISTANCE_FRONT}, dist_m[0]);
    check({tag, "_sfront"}, {24'd0, DISTANCE_SIDE_FRONT}, dist_m[1]);
    check({tag, "_sback"}, {24'd0, DISTANCE_SIDE_BACK}, dist_m[2]);
  endtask

  // One full slot: trigger, echo of n synced cycles (0 = no echo), result, pulse width.
  task automatic run_slot(input int n, input bit drop_enable);
    int s, o, w, t, d;
    s = order_of(ptr_m);
    o = (s + 1) % 3;
    t = 0;
    while (TRIG == 3'b000 && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    check("trig_seen", {31'd0, TRIG != 3'b000}, 1);
    check("trig_sel", {29'd0, TRIG}, 32'd1 << s);
    check("busy_in_slot", {31'd0, BUSY}, 1);
    w = 0;
    while (TRIG != 3'b000 && w < 100) begin
      w++;
      @(negedge CLK);
    end
    check("trig_width", w, TRIG_CYCLES);
    t = 0;
    if (n == 0) begin
      while (!(NO_ECHO || DIST_VALID) && t < ECHO_TIMEOUT + 100) begin
        @(negedge CLK);
        t++;
      end
      check("timeout_latency", t, ECHO_TIMEOUT);
      dist_m[s] = 255;
    end else begin
      d = $urandom_range(0, 30);
      repeat (d) @(negedge CLK);
      ECHO[s] = 1'b1;
      ECHO[o] = 1'b1;
      for (int i = 0; i < n; i++) begin
        if (i == n / 2) ECHO[o] = 1'b0;
        if (drop_enable && i == n / 2) ENABLE = 1'b0;
        @(negedge CLK);
      end
      ECHO = 3'b000;
      while (!(NO_ECHO || DIST_VALID) && t < 50) begin
        @(negedge CLK);
        t++;
      end
      dist_m[s] = expected_cm(n);
    end
    check("dist_valid", {31'd0, DIST_VALID}, (n != 0) ? 1 : 0);
    check("no_echo", {31'd0, NO_ECHO}, (n == 0) ? 1 : 0);
    check("dist_id", {30'd0, DIST_ID}, s);
    check_distances("dist");
    @(negedge CLK);
    check("pulse_width", {30'd0, DIST_VALID, NO_ECHO}, 0);
    ptr_m = (ptr_m + 1) % slot_count();
  endtask

  initial begin
    int t, n;
    RESET_N = 1'b0;
    ENABLE  = 1'b0;
    ECHO    = 3'b000;
    model_reset();
    repeat (3) @(negedge CLK);
    check("rst_trig", {29'd0, TRIG}, 0);
    check("rst_busy", {31'd0, BUSY}, 0);
    check("rst_valid", {31'd0, DIST_VALID}, 0);
    check("rst_no_echo", {31'd0, NO_ECHO}, 0);
    check("rst_id", {30'd0, DIST_ID}, 0);
    check_distances("rst");
    RESET_N = 1'b1;
    @(negedge CLK);
    ENABLE = 1'b1;

    // Directed: 305 cycles -> 30 cm, saturating 2600-cycle echo, missing echo.
    run_slot(305, 1'b0);
    run_slot(2600, 1'b0);
    run_slot(0, 1'b0);

    // ENABLE dropped mid-measurement: slot completes, then idles.
    run_slot(100, 1'b1);
    t = 0;
    while (BUSY && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check("idle_after_disable", {31'd0, BUSY}, 0);
    repeat (30) @(negedge CLK);
    check("idle_trig", {29'd0, TRIG}, 0);
    check("idle_busy", {31'd0, BUSY}, 0);

    // Reset while the trigger is high: trigger drops at once, distances return to far.
    ENABLE = 1'b1;
    t = 0;
    while (TRIG == 3'b000 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    check("trig_before_reset", {29'd0, TRIG}, 32'd1 << order_of(ptr_m));
    @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("reset_trig_drop", {29'd0, TRIG}, 0);
    check("reset_busy", {31'd0, BUSY}, 0);
    model_reset();
    check_distances("reset_mid");
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;

    // Free run: slot order and results against the model.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 7) == 0) n = 0;
      else if ($urandom_range(0, 5) == 0) n = $urandom_range(2540, 2700);
      else n = $urandom_range(1, 400);
      run_slot(n, 1'b0);
    end

    ENABLE = 1'b0;
    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
